// File: rtl/fwd_mux_pipe.sv
// EX-stage forwarding operand mux with a registered output, stall hold, flush,
// capture-on-stall and a stall-length counter. Optional statistics: FWD_STATS_EN.
module fwd_mux_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [(1<<SEL_W)*WIDTH-1:0]    data_in,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           valid_in,
    input  logic                           stall,
    input  logic                           flush,
    output logic [WIDTH-1:0]               data_out,
    output logic                           valid_out,
    output logic                           held,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [15:0]                    fwd_count
);

    localparam int unsigned NUM_SRC = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mux_val = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) mux_val = data_in[k*WIDTH +: WIDTH];
        end
    end

    // Priority: flush > stall > advance (reset handled in the register block).
    always_comb begin
        data_d  = data_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        if (flush) begin
            data_d  = '0;
            valid_d = 1'b0;
            held_d  = 1'b0;
            cnt_d   = '0;
        end else if (stall) begin
            if (!held_q && valid_in) begin
                hold_d = mux_val;
                held_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            data_d  = held_q ? hold_q : mux_val;
            valid_d = valid_in;
            held_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign held      = held_q;
    assign stall_cnt = cnt_q;

`ifdef FWD_STATS_EN
    logic [SEL_W-1:0] sel_hold_q, sel_hold_d;
    logic [15:0]      fwd_q, fwd_d;
    logic [SEL_W-1:0] eff_sel;

    // A held operand is counted against the select that was live when it was captured.
    always_comb begin
        eff_sel    = held_q ? sel_hold_q : sel;
        sel_hold_d = sel_hold_q;
        fwd_d      = fwd_q;
        if (!flush && stall && !held_q && valid_in) sel_hold_d = sel;
        if (!flush && !stall && valid_in && (eff_sel != '0) && (fwd_q != 16'hFFFF))
            fwd_d = fwd_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_hold_q <= '0;
            fwd_q      <= '0;
        end else begin
            sel_hold_q <= sel_hold_d;
            fwd_q      <= fwd_d;
        end
    end

    assign fwd_count = fwd_q;
`else
    assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Directed bench for fwd_mux_pipe: a vector table for cycle-by-cycle behaviour
// plus hand sequences for counter saturation and forwarding statistics.
module tb_fwd_mux_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NVEC  = 20;

    logic               clk = 1'b0;
    logic               reset;
    logic [127:0]       data_in;
    logic [1:0]         sel;
    logic               valid_in, stall, flush;
    logic [31:0]        data_out;
    logic               valid_out, held;
    logic [3:0]         stall_cnt;
    logic [15:0]        fwd_count;

    int tests  = 0;
    int errors = 0;

    fwd_mux_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .sel       (sel),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .data_out  (data_out),
        .valid_out (valid_out),
        .held      (held),
        .stall_cnt (stall_cnt),
        .fwd_count (fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [127:0] din;
        logic [1:0]   sel;
        logic         v;
        logic         st;
        logic         fl;
        logic [31:0]  e_do;
        logic         e_vo;
        logic         e_h;
        logic [3:0]   e_c;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(logic rst, logic [127:0] din, logic [1:0] s, logic v,
                                logic st, logic fl, logic [31:0] e_do, logic e_vo,
                                logic e_h, logic [3:0] e_c);
        vec_t r;
        r.rst = rst; r.din = din; r.sel = s; r.v = v; r.st = st; r.fl = fl;
        r.e_do = e_do; r.e_vo = e_vo; r.e_h = e_h; r.e_c = e_c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [127:0] din, input logic [1:0] s,
                         input logic v, input logic st, input logic fl);
        reset = rst; data_in = din; sel = s; valid_in = v; stall = st; flush = fl;
    endtask

    // Let the DUT take one edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] d0, d1;
    logic [15:0]  exp_fwd;

    initial begin
        d0 = {32'h44, 32'h33, 32'h22, 32'h11};
        d1 = {32'h44, 32'h33, 32'hDEAD, 32'h11};

        //              rst  din sel v  st fl  data_out    vo h  cnt
        vecs[0]  = mk(1'b1, d0, 2'd0, 0, 0, 0, 32'h0,      0, 0, 4'd0); // reset state
        vecs[1]  = mk(1'b0, d0, 2'd2, 1, 0, 0, 32'h33,     1, 0, 4'd0); // basic select
        vecs[2]  = mk(1'b0, d0, 2'd1, 1, 1, 0, 32'h33,     1, 1, 4'd1); // capture 0x22
        vecs[3]  = mk(1'b0, d1, 2'd0, 1, 1, 0, 32'h33,     1, 1, 4'd2); // changes ignored
        vecs[4]  = mk(1'b0, d1, 2'd0, 1, 1, 0, 32'h33,     1, 1, 4'd3);
        vecs[5]  = mk(1'b0, d1, 2'd0, 1, 0, 0, 32'h22,     1, 0, 4'd0); // release shows held
        vecs[6]  = mk(1'b0, d1, 2'd0, 1, 0, 0, 32'h11,     1, 0, 4'd0); // back to live
        vecs[7]  = mk(1'b0, d0, 2'd3, 1, 1, 0, 32'h11,     1, 1, 4'd1); // capture 0x44
        vecs[8]  = mk(1'b0, d0, 2'd2, 1, 1, 1, 32'h0,      0, 0, 4'd0); // flush beats stall
        vecs[9]  = mk(1'b0, d0, 2'd2, 1, 0, 0, 32'h33,     1, 0, 4'd0); // live, not 0x44
        vecs[10] = mk(1'b0, d0, 2'd1, 0, 1, 0, 32'h33,     1, 0, 4'd1); // invalid: no capture
        vecs[11] = mk(1'b0, d0, 2'd1, 0, 0, 0, 32'h22,     0, 0, 4'd0);
        vecs[12] = mk(1'b0, d0, 2'd3, 1, 1, 0, 32'h22,     0, 1, 4'd1); // one-cycle stall
        vecs[13] = mk(1'b0, d1, 2'd0, 1, 0, 0, 32'h44,     1, 0, 4'd0);
        vecs[14] = mk(1'b0, d0, 2'd2, 1, 1, 0, 32'h44,     1, 1, 4'd1);
        vecs[15] = mk(1'b0, d0, 2'd2, 1, 1, 0, 32'h44,     1, 1, 4'd2);
        vecs[16] = mk(1'b1, d0, 2'd2, 1, 1, 0, 32'h0,      0, 0, 4'd0); // reset mid stall
        vecs[17] = mk(1'b0, d0, 2'd3, 1, 0, 0, 32'h44,     1, 0, 4'd0);
        vecs[18] = mk(1'b0, d0, 2'd1, 1, 0, 1, 32'h0,      0, 0, 4'd0); // plain flush
        vecs[19] = mk(1'b0, d0, 2'd0, 0, 0, 0, 32'h11,     0, 0, 4'd0);

        drive(1'b1, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].rst, vecs[i].din, vecs[i].sel, vecs[i].v, vecs[i].st, vecs[i].fl);
            tick();
            chk($sformatf("v%0d data_out", i), data_out, vecs[i].e_do);
            chk($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(vecs[i].e_vo));
            chk($sformatf("v%0d held", i), 32'(held), 32'(vecs[i].e_h));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_c));
        end

        // Long stall: counter saturates at 15, clears on the advance.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, d0, 2'd1, 1'b1, 1'b1, 1'b0);
            tick();
            chk($sformatf("sat%0d stall_cnt", i), 32'(stall_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        drive(1'b0, d0, 2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sat release stall_cnt", 32'(stall_cnt), 32'd0);
        chk("sat release data_out", data_out, 32'h22);
        chk("sat release held", 32'(held), 32'd0);

        // Forwarding statistics.
        drive(1'b1, d0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fwd after reset", 32'(fwd_count), 32'd0);
        begin
            logic [1:0] seq [5];
            seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0; seq[4] = 2'd3;
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, d0, seq[i], 1'b1, 1'b0, 1'b0);
                tick();
            end
        end
`ifdef FWD_STATS_EN
        exp_fwd = 16'd3;
`else
        exp_fwd = 16'd0;
`endif
        chk("fwd after 5 advances", 32'(fwd_count), 32'(exp_fwd));
        chk("fwd last data_out", data_out, 32'h44);

        // Captured sel=2 must count even though live sel is 0 at the advance.
        drive(1'b0, d0, 2'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, d0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef FWD_STATS_EN
        exp_fwd = 16'd4;
`endif
        chk("fwd held sel", 32'(fwd_count), 32'(exp_fwd));
        chk("fwd held data_out", data_out, 32'h33);

        // Flush neither counts nor clears.
        drive(1'b0, d0, 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("fwd across flush", 32'(fwd_count), 32'(exp_fwd));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
